// File: rtl/vga_pkg.sv
// Shared types and constants for the framebuffer arbiter slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package vga_pkg;

  // Who owns the RAM port in a given cycle.
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_DISP   = 2'd1,
    OWN_CPU_RD = 2'd2,
    OWN_CPU_WR = 2'd3
  } owner_t;

  // Visible-area timing and framebuffer size.
  localparam int H_VA     = 640;
  localparam int V_VA     = 480;
  localparam int FB_WORDS = H_VA * V_VA;

  // Default framebuffer word address / data widths.
  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 16;

  // Only reads need a return tag; writes complete silently.
  function automatic logic is_read(owner_t o);
    return (o == OWN_DISP) || (o == OWN_CPU_RD);
  endfunction

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Read-return tag delay line: carries the issuing owner alongside the RAM read.
// Latency: RAM_LAT cycles from tag_in to tag_out.
// Backpressure: none; one tag enters every cycle, clear drops everything in flight.
module fb_rd_tag_pipe
  import vga_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tag_in,
  output logic [1:0] tag_out
);

  owner_t pipe [RAM_LAT];

  // Shift tags towards the output; reset discards every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAM_LAT; i++) pipe[i] <= OWN_NONE;
    end else begin
      pipe[0] <= owner_t'(tag_in);
      for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RAM_LAT-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display has priority, CPU has a bounded-wait override.
// Latency: grant same cycle, ram_* one cycle later, read data grant+1+RAM_LAT.
// Backpressure: CPU stalls via cpu_ready=0 (must hold request); display is re-sampled each cycle.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic              disp_urgent,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [7:0]        starve_cnt;
  logic              force_cpu;
  owner_t            state;
  owner_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        tag_in;
  logic [1:0]        tag_out;
  logic [DATA_W-1:0] disp_hold;
  logic [DATA_W-1:0] cpu_hold;

  // The override only fires once the CPU has waited its full budget, and
  // never while the display FIFO is close to running dry.
  assign force_cpu = (starve_cnt == 8'(STARVE_MAX)) & cpu_valid & ~disp_urgent;
  assign disp_gnt  = ~rst & disp_req & ~force_cpu;
  assign cpu_ready = ~rst & cpu_valid & (~disp_req | force_cpu);

  // Count consecutive denied CPU cycles; saturation also covers the urgent hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (!cpu_valid || cpu_ready) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != 8'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Owner state register.
  always_ff @(posedge clk) begin
    if (rst) state <= OWN_NONE;
    else     state <= state_nxt;
  end

  // Next owner is whoever was granted this cycle.
  always_comb begin
    state_nxt = OWN_NONE;
    if (disp_gnt)       state_nxt = OWN_DISP;
    else if (cpu_ready) state_nxt = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
  end

  // Capture the granted request so the RAM sees it registered next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (disp_gnt) begin
      addr_q  <= disp_addr;
    end else if (cpu_ready) begin
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
    end
  end

  assign ram_en    = (state != OWN_NONE);
  assign ram_we    = (state == OWN_CPU_WR);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  // Only reads launch a tag; writes leave a bubble in the return pipe.
  assign tag_in = is_read(state) ? state : OWN_NONE;

  fb_rd_tag_pipe #(
    .RAM_LAT (RAM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign disp_rvalid = (owner_t'(tag_out) == OWN_DISP);
  assign cpu_rvalid  = (owner_t'(tag_out) == OWN_CPU_RD);

  // Remember the last returned word per port so rdata holds between returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_hold <= '0;
      cpu_hold  <= '0;
    end else begin
      if (disp_rvalid) disp_hold <= ram_rdata;
      if (cpu_rvalid)  cpu_hold  <= ram_rdata;
    end
  end

  // Returned word is forwarded in its valid cycle, held value otherwise.
  assign disp_rdata = disp_rvalid ? ram_rdata : disp_hold;
  assign cpu_rdata  = cpu_rvalid  ? ram_rdata : cpu_hold;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized scoreboard bench for the framebuffer arbiter with a behavioural RAM.
// Latency: checks grants same cycle, RAM bus +1, read returns +1+RL.
// Backpressure: CPU driver holds its request until accepted.
module tb_vga_fb_arbiter;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int RL = 3;
  localparam int SM = 8;

  logic          clk;
  logic          rst;
  logic          disp_req, disp_urgent;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt, disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          cpu_valid, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  vga_fb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(RL), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_urgent(disp_urgent), .disp_addr(disp_addr),
    .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;
  bit started = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Unwritten framebuffer words have an address-derived pattern.
  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return 16'(a * 7) ^ 16'hA55A;
  endfunction

  // ---------------- behavioural synchronous RAM, latency RL ----------------
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  logic [DW-1:0] rpipe   [RL];
  assign ram_rdata = rpipe[RL-1];

  always @(posedge clk) begin
    logic [DW-1:0] rd;
    rd = 16'($urandom);
    if (ram_en && ram_we) ram_mem[ram_addr] = ram_wdata;
    if (ram_en && !ram_we) rd = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_val(ram_addr);
    for (int i = RL-1; i > 0; i--) rpipe[i] <= rpipe[i-1];
    rpipe[0] <= rd;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int due; logic [DW-1:0] data; } exp_t;
  exp_t dq[$];
  exp_t cq[$];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  int            wait_cnt = 0;
  bit            cpu_acc  = 0;
  logic [DW-1:0] last_d = '0, last_c = '0;
  bit            exp_en = 0, exp_we = 0, exp_zero = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  function automatic logic [DW-1:0] shadow_rd(logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  // Cycle count, and reset drops every read that would return after it.
  always @(posedge clk) begin
    if (rst) begin
      while (dq.size() > 0 && dq[dq.size()-1].due > cyc) void'(dq.pop_back());
      while (cq.size() > 0 && cq[cq.size()-1].due > cyc) void'(cq.pop_back());
      last_d = '0;
      last_c = '0;
      wait_cnt = 0;
    end
    cyc++;
  end

  // Arbitration and RAM-bus model: expectations pushed at grant time.
  always @(negedge clk) begin
    if (started) begin
      bit frc, edg, ecr;
      exp_t e;
      check("ram_en", 32'(ram_en), 32'(exp_en));
      check("ram_we", 32'(ram_we), 32'(exp_we));
      if (exp_en || exp_zero) check("ram_addr", 32'(ram_addr), 32'(exp_addr));
      if (exp_we || exp_zero) check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));

      frc = (wait_cnt == SM) && cpu_valid && !disp_urgent;
      edg = !rst && disp_req && !frc;
      ecr = !rst && cpu_valid && (!disp_req || frc);
      check("disp_gnt", 32'(disp_gnt), 32'(edg));
      check("cpu_ready", 32'(cpu_ready), 32'(ecr));

      exp_en = 0; exp_we = 0; exp_zero = rst;
      if (rst) begin exp_addr = '0; exp_wdata = '0; end
      if (edg) begin
        exp_en = 1; exp_addr = disp_addr;
        e.due = cyc + 1 + RL; e.data = shadow_rd(disp_addr);
        dq.push_back(e);
      end else if (ecr) begin
        exp_en = 1; exp_addr = cpu_addr;
        if (cpu_we) begin
          exp_we = 1; exp_wdata = cpu_wdata;
          shadow[cpu_addr] = cpu_wdata;
        end else begin
          e.due = cyc + 1 + RL; e.data = shadow_rd(cpu_addr);
          cq.push_back(e);
        end
      end

      // Consecutive denied CPU cycles, capped at the budget.
      if (rst || !cpu_valid || ecr) wait_cnt = 0;
      else if (wait_cnt < SM) wait_cnt++;
      cpu_acc = ecr;
    end
  end

  // Monitor: pops an expectation whenever a return is due, else expects silence.
  always @(negedge clk) begin
    if (started) begin
      if (dq.size() > 0 && dq[0].due == cyc) begin
        check("disp_rvalid", 32'(disp_rvalid), 32'd1);
        check("disp_rdata", 32'(disp_rdata), 32'(dq[0].data));
        last_d = dq[0].data;
        void'(dq.pop_front());
      end else begin
        check("disp_rvalid_idle", 32'(disp_rvalid), 32'd0);
        check("disp_rdata_hold", 32'(disp_rdata), 32'(last_d));
      end
      if (cq.size() > 0 && cq[0].due == cyc) begin
        check("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("cpu_rdata", 32'(cpu_rdata), 32'(cq[0].data));
        last_c = cq[0].data;
        void'(cq.pop_front());
      end else begin
        check("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
        check("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_c));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    disp_req = 0; cpu_valid = 0; disp_urgent = 0;
    repeat (n) step();
  endtask

  initial begin
    rst = 1; disp_req = 1; disp_urgent = 0; disp_addr = '0;
    cpu_valid = 1; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;

    // Reset held three cycles with both requesters active.
    step(); started = 1;
    step(); step();
    rst = 0;
    idle(4);

    // Single display read.
    disp_req = 1; disp_addr = 19'h00100;
    step();
    idle(RL + 4);

    // CPU write then read-back of the same word.
    cpu_valid = 1; cpu_we = 1; cpu_addr = 19'h12345; cpu_wdata = 16'hBEEF;
    step();
    cpu_we = 0;
    step();
    idle(RL + 4);

    // Continuous display traffic against a waiting CPU read.
    disp_req = 1; cpu_valid = 1; cpu_we = 0; cpu_addr = 19'h00200;
    for (int i = 0; i < 12; i++) begin
      disp_addr = 19'(i);
      step();
    end
    idle(RL + 4);

    // Urgent display blocks the override, then releases it.
    disp_req = 1; disp_urgent = 1;
    cpu_valid = 1; cpu_we = 1; cpu_addr = 19'h00300; cpu_wdata = 16'h1111;
    repeat (20) step();
    disp_urgent = 0;
    step();
    cpu_valid = 0;
    step();
    idle(RL + 4);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      disp_req = ($urandom_range(0, 9) < 7);
      disp_urgent = ($urandom_range(0, 9) == 0);
      disp_addr = 19'($urandom_range(0, 15));
      if (!cpu_valid || cpu_acc) begin
        cpu_valid = ($urandom_range(0, 9) < 6);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = 19'($urandom_range(0, 15));
        cpu_wdata = 16'($urandom);
      end
      step();
    end
    rst = 0;
    idle(RL + 4);

    // Reset one cycle after the third of three back-to-back display reads.
    for (int i = 0; i < 3; i++) begin
      disp_req = 1; disp_addr = 19'h00010 + 19'(i);
      step();
    end
    disp_req = 0; rst = 1;
    step();
    step();
    rst = 0;
    idle(RL + 8);

    check("disp_queue_drained", 32'(dq.size()), 32'd0);
    check("cpu_queue_drained", 32'(cq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
